// File: rtl/state_report_if.sv
// state_report_if: bundles the state snapshot inputs, report request and UART byte handshake.
interface state_report_if;
    logic [2:0]  state;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;
    logic        req;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    modport master (
        output state, state_freq, state_amp, state_phase, req, tx_ready,
        input  tx_data, tx_valid, busy
    );

    modport slave (
        input  state, state_freq, state_amp, state_phase, req, tx_ready,
        output tx_data, tx_valid, busy
    );
endinterface

// File: rtl/state_report.sv
// state_report: snapshots the generator state and emits it as an ASCII frame over a byte handshake.
// Define REPORT_CRLF_EN to append CR LF to every frame (7 bytes instead of 5).
module state_report #(
    parameter logic [7:0] FRAME_HDR   = 8'h66,
    parameter int         AUTO_PERIOD = 0
) (
    input logic           clk,
    input logic           rst_n,
    state_report_if.slave bus
);
    typedef enum logic {IDLE, SEND} st_t;

`ifdef REPORT_CRLF_EN
    localparam logic [2:0] LAST = 3'd6;
`else
    localparam logic [2:0] LAST = 3'd4;
`endif

    st_t         st_q, st_d;
    logic [2:0]  idx_q, idx_d;
    logic        pend_q, pend_d;
    logic [2:0]  s_state_q, s_state_d;
    logic [11:0] s_freq_q, s_freq_d;
    logic [2:0]  s_amp_q, s_amp_d;
    logic [7:0]  s_phase_q, s_phase_d;
    logic        auto_req, req_any, xfer, take;
    logic [7:0]  byte_sel;

    function automatic logic [7:0] dig(input logic [11:0] v);
        return (v <= 12'd9) ? 8'h30 + v[7:0] : 8'h3F;
    endfunction

    generate
        if (AUTO_PERIOD > 0) begin : g_auto
            localparam int CW = AUTO_PERIOD > 1 ? $clog2(AUTO_PERIOD) : 1;
            logic [CW-1:0] cnt_q, cnt_d;
            always_comb cnt_d = (cnt_q == CW'(AUTO_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            assign auto_req = (cnt_q == CW'(AUTO_PERIOD - 1));
        end else begin : g_no_auto
            assign auto_req = 1'b0;
        end
    endgenerate

    assign req_any = bus.req | auto_req;
    assign xfer    = (st_q == SEND) && bus.tx_ready;

    // A frame end with a request pending (or arriving now) restarts directly into SEND.
    always_comb begin
        st_d   = st_q;
        idx_d  = idx_q;
        pend_d = pend_q;
        take   = 1'b0;
        if (st_q == IDLE) begin
            if (req_any) begin
                st_d  = SEND;
                idx_d = 3'd0;
                take  = 1'b1;
            end
        end else if (xfer && idx_q == LAST) begin
            idx_d  = 3'd0;
            pend_d = 1'b0;
            take   = pend_q | req_any;
            st_d   = (pend_q | req_any) ? SEND : IDLE;
        end else begin
            if (xfer) idx_d = idx_q + 3'd1;
            if (req_any) pend_d = 1'b1;
        end
    end

    always_comb begin
        s_state_d = take ? bus.state       : s_state_q;
        s_freq_d  = take ? bus.state_freq  : s_freq_q;
        s_amp_d   = take ? bus.state_amp   : s_amp_q;
        s_phase_d = take ? bus.state_phase : s_phase_q;
    end

    always_comb begin
        byte_sel = 8'h00;
        case (idx_q)
            3'd0:    byte_sel = FRAME_HDR;
            3'd1:    byte_sel = dig({9'd0, s_state_q});
            3'd2:    byte_sel = dig(s_freq_q);
            3'd3:    byte_sel = dig({9'd0, s_amp_q});
            3'd4:    byte_sel = dig({4'd0, s_phase_q});
            3'd5:    byte_sel = 8'h0D;
            3'd6:    byte_sel = 8'h0A;
            default: byte_sel = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= IDLE;
            idx_q     <= 3'd0;
            pend_q    <= 1'b0;
            s_state_q <= 3'd0;
            s_freq_q  <= 12'd0;
            s_amp_q   <= 3'd0;
            s_phase_q <= 8'd0;
        end else begin
            st_q      <= st_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            s_state_q <= s_state_d;
            s_freq_q  <= s_freq_d;
            s_amp_q   <= s_amp_d;
            s_phase_q <= s_phase_d;
        end
    end

    assign bus.tx_valid = (st_q == SEND);
    assign bus.busy     = (st_q == SEND);
    assign bus.tx_data  = (st_q == SEND) ? byte_sel : 8'h00;
endmodule

// File: tb/tb_state_report.sv
// tb_state_report: directed vector table plus hand-written sequences for state_report.
module tb_state_report;
`ifdef REPORT_CRLF_EN
    localparam int FL = 7;
`else
    localparam int FL = 5;
`endif

    typedef logic [0:4][7:0] f5_t;
    typedef struct {
        logic [2:0]  s;
        logic [11:0] f;
        logic [2:0]  am;
        logic [7:0]  p;
        f5_t         e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] rx_d[$];
    int         rx_t[$];
    int         a_st[$];

    state_report_if m();
    state_report_if a();

    state_report dut (.clk(clk), .rst_n(rst_n), .bus(m.slave));
    state_report #(.AUTO_PERIOD(20)) dut_auto (.clk(clk), .rst_n(rst_n), .bus(a.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m.tx_valid && m.tx_ready) begin
            rx_d.push_back(m.tx_data);
            rx_t.push_back(cyc);
        end
        if (a.tx_valid && a.tx_ready && a.tx_data == 8'h66) a_st.push_back(cyc);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] s, input logic [11:0] f, input logic [2:0] am, input logic [7:0] p);
        m.state = s; m.state_freq = f; m.state_amp = am; m.state_phase = p;
    endtask

    task automatic pulse_req();
        @(posedge clk); #1 m.req = 1'b1;
        @(posedge clk); #1 m.req = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_frame(input string nm, input f5_t e, input int base);
        logic [7:0] exp;
        if (rx_d.size() < base + FL) begin
            checks++; errors++;
            $display("FAIL %s: only %0d bytes received, need %0d", nm, rx_d.size(), base + FL);
            return;
        end
        for (int i = 0; i < FL; i++) begin
            exp = (i < 5) ? e[i] : (i == 5 ? 8'h0D : 8'h0A);
            chk($sformatf("%s byte%0d", nm, i), {24'd0, rx_d[base+i]}, {24'd0, exp});
            if (i > 0) chk($sformatf("%s gap%0d", nm, i), rx_t[base+i], rx_t[base+i-1] + 1);
        end
    endtask

    initial begin
        vec_t tv[6];
        int t;
        tv[0] = '{3'd2, 12'd5,    3'd3, 8'd7,   {8'h66, 8'h32, 8'h35, 8'h33, 8'h37}};
        tv[1] = '{3'd0, 12'd100,  3'd9 & 3'd7, 8'd10, {8'h66, 8'h30, 8'h3F, 8'h31, 8'h3F}};
        tv[2] = '{3'd7, 12'd9,    3'd0, 8'd9,   {8'h66, 8'h37, 8'h39, 8'h30, 8'h39}};
        tv[3] = '{3'd1, 12'd10,   3'd7, 8'd255, {8'h66, 8'h31, 8'h3F, 8'h37, 8'h3F}};
        tv[4] = '{3'd4, 12'd4095, 3'd6, 8'd0,   {8'h66, 8'h34, 8'h3F, 8'h36, 8'h30}};
        tv[5] = '{3'd5, 12'd256,  3'd1, 8'h80,  {8'h66, 8'h35, 8'h3F, 8'h31, 8'h3F}};
        set_in(3'd0, 12'd0, 3'd0, 8'd0);
        m.req = 1'b0; m.tx_ready = 1'b1;
        a.state = 3'd2; a.state_freq = 12'd5; a.state_amp = 3'd3; a.state_phase = 8'd7;
        a.req = 1'b0; a.tx_ready = 1'b1;
        #12;
        chk("reset tx_valid", {31'd0, m.tx_valid}, 32'd0);
        chk("reset busy", {31'd0, m.busy}, 32'd0);
        chk("reset tx_data", {24'd0, m.tx_data}, 32'd0);
        chk("reset auto tx_valid", {31'd0, a.tx_valid}, 32'd0);
        #10 rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            set_in(tv[v].s, tv[v].f, tv[v].am, tv[v].p);
            wait_cycles(2);
            rx_d.delete(); rx_t.delete();
            chk($sformatf("v%0d idle valid", v), {31'd0, m.tx_valid}, 32'd0);
            pulse_req();
            chk($sformatf("v%0d busy rise", v), {31'd0, m.busy}, 32'd1);
            chk($sformatf("v%0d valid rise", v), {31'd0, m.tx_valid}, 32'd1);
            set_in(3'd6, 12'd1, 3'd2, 8'd3);
            wait_cycles(FL + 3);
            chk($sformatf("v%0d count", v), rx_d.size(), FL);
            chk_frame($sformatf("v%0d", v), tv[v].e, 0);
            chk($sformatf("v%0d busy end", v), {31'd0, m.busy}, 32'd0);
        end

        set_in(3'd2, 12'd5, 3'd3, 8'd7);
        rx_d.delete(); rx_t.delete();
        pulse_req();
        wait_cycles(2);
        m.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d valid", i), {31'd0, m.tx_valid}, 32'd1);
            chk($sformatf("stall%0d data", i), {24'd0, m.tx_data}, 32'h35);
        end
        @(posedge clk); #1 m.tx_ready = 1'b1;
        wait_cycles(FL + 3);
        chk("stall count", rx_d.size(), FL);
        if (rx_d.size() >= 3) begin
            chk("stall b1", {24'd0, rx_d[1]}, 32'h32);
            chk("stall b2", {24'd0, rx_d[2]}, 32'h35);
            chk("stall b3", {24'd0, rx_d[3]}, 32'h33);
            chk("stall b4", {24'd0, rx_d[4]}, 32'h37);
        end

        set_in(3'd1, 12'd2, 3'd3, 8'd4);
        rx_d.delete(); rx_t.delete();
        pulse_req();
        set_in(3'd5, 12'd6, 3'd7, 8'd8);
        for (int i = 0; i < 3; i++) begin
            m.req = 1'b1;
            @(posedge clk); #1 m.req = 1'b0;
            @(posedge clk); #1;
        end
        wait_cycles(3 * FL);
        chk("pend count", rx_d.size(), 2 * FL);
        chk_frame("pend A", {8'h66, 8'h31, 8'h32, 8'h33, 8'h34}, 0);
        chk_frame("pend B", {8'h66, 8'h35, 8'h36, 8'h37, 8'h38}, FL);
        if (rx_d.size() >= 2 * FL) chk("pend b2b", rx_t[FL], rx_t[FL-1] + 1);
        chk("pend busy end", {31'd0, m.busy}, 32'd0);

        set_in(3'd3, 12'd3, 3'd3, 8'd3);
        rx_d.delete(); rx_t.delete();
        pulse_req();
        set_in(3'd6, 12'd0, 3'd1, 8'd2);
        repeat (FL - 1) @(posedge clk);
        #1 m.req = 1'b1;
        @(posedge clk); #1 m.req = 1'b0;
        wait_cycles(2 * FL + 2);
        chk("lastreq count", rx_d.size(), 2 * FL);
        chk_frame("lastreq A", {8'h66, 8'h33, 8'h33, 8'h33, 8'h33}, 0);
        chk_frame("lastreq B", {8'h66, 8'h36, 8'h30, 8'h31, 8'h32}, FL);
        if (rx_d.size() >= 2 * FL) chk("lastreq b2b", rx_t[FL], rx_t[FL-1] + 1);

        set_in(3'd2, 12'd5, 3'd3, 8'd7);
        rx_d.delete(); rx_t.delete();
        pulse_req();
        wait_cycles(3);
        rst_n = 1'b0;
        #1;
        chk("rst valid", {31'd0, m.tx_valid}, 32'd0);
        chk("rst busy", {31'd0, m.busy}, 32'd0);
        chk("rst data", {24'd0, m.tx_data}, 32'd0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(10);
        chk("rst no resume", rx_d.size(), 3);
        rx_d.delete(); rx_t.delete();
        pulse_req();
        wait_cycles(FL + 3);
        chk("rst new count", rx_d.size(), FL);
        chk_frame("rst new", {8'h66, 8'h32, 8'h35, 8'h33, 8'h37}, 0);

        a_st.delete();
        t = 0;
        while (a_st.size() < 1 && t < 100) begin @(posedge clk); #1; t++; end
        if (a_st.size() < 1) begin
            checks++; errors++;
            $display("FAIL auto start: no frame within %0d cycles", t);
        end else begin
            t = a_st[0] + 19;
            while (cyc < t) begin @(posedge clk); #1; end
            a.req = 1'b1;
            @(posedge clk); #1 a.req = 1'b0;
            wait_cycles(85);
            chk("auto frames", {31'd0, a_st.size() >= 5}, 32'd1);
            for (int i = 1; i < a_st.size(); i++)
                chk($sformatf("auto period%0d", i), a_st[i] - a_st[i-1], 20);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
